// File: rtl/jz_seg7_display_ctrl.sv
// jz_seg7_display_ctrl: bus-mapped 8-digit multiplexed seven-segment driver.
// Ports: clk, rst (async high), ce/we/addr/sel/data_i/data_o bus, an_n, seg_n.
// Registers: 0 DATA, 1 DPMASK, 2 DIGEN, 3 BLINK (present with SEG7_BLINK_EN).
module jz_seg7_display_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [7:0]  an_n,
  output logic [7:0]  seg_n
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  logic [31:0]   data_r;
  logic [7:0]    dpmask;
  logic [7:0]    digen;
  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic          slot_end;
  logic          blank;
  logic          lit;
  logic [3:0]    digit;
  logic [31:0]   rd_val;
  logic          unused_ok;

  assign slot_end = (presc == PMAX);
  assign digit    = data_r[{idx, 2'b00} +: 4];
  assign lit      = digen[idx] & ~blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

  logic [7:0]    blink_r;
  logic [FW-1:0] frame;
  logic          phase;

  assign blank     = phase & blink_r[idx];
  assign unused_ok = ^addr[1:0];

  // Frame counter advances when the scan wraps from digit 7 to digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame <= '0;
      phase <= 1'b0;
    end else if (slot_end && idx == 3'd7) begin
      if (frame == FMAX) begin
        frame <= '0;
        phase <= ~phase;
      end else begin
        frame <= frame + 1'b1;
      end
    end
  end
`else
  assign blank     = 1'b0;
  assign unused_ok = ^{addr[1:0], BLINK_FRAMES[0]};
`endif

  // Register writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r  <= '0;
      dpmask  <= '0;
      digen   <= 8'hFF;
`ifdef SEG7_BLINK_EN
      blink_r <= '0;
`endif
    end else if (ce && we) begin
      case (addr[3:2])
        2'd0: begin
          for (int i = 0; i < 4; i++)
            if (sel[i]) data_r[8*i +: 8] <= data_i[8*i +: 8];
        end
        2'd1: if (sel[0]) dpmask <= data_i[7:0];
        2'd2: if (sel[0]) digen  <= data_i[7:0];
`ifdef SEG7_BLINK_EN
        2'd3: if (sel[0]) blink_r <= data_i[7:0];
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr[3:2])
      2'd0: rd_val = data_r;
      2'd1: rd_val = {24'b0, dpmask};
      2'd2: rd_val = {24'b0, digen};
`ifdef SEG7_BLINK_EN
      2'd3: rd_val = {24'b0, blink_r};
`endif
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      data_o <= '0;
    else if (ce && !we)
      data_o <= rd_val;
  end

  // Scan timing: each digit owns SCAN_DIV cycles, lit or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (slot_end) begin
      presc <= '0;
      idx   <= idx + 3'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_n  <= 8'hFF;
      seg_n <= 8'hFF;
    end else if (lit) begin
      an_n  <= ~(8'b1 << idx);
      seg_n <= {~dpmask[idx], hex7(digit)};
    end else begin
      an_n  <= 8'hFF;
      seg_n <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_jz_seg7_display_ctrl.sv
// tb_jz_seg7_display_ctrl: directed bench with a cycle-indexed display model.
// Checks every cycle plus hand-computed literal points.
module tb_jz_seg7_display_ctrl;

  localparam int SD = 4;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic [7:0]  an_n;
  logic [7:0]  seg_n;

  jz_seg7_display_ctrl #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .an_n(an_n), .seg_n(seg_n)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int n = 0;

  logic [6:0] hexc [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic [31:0] m_data;
  logic [7:0]  m_dp, m_en, m_bl;
  logic [31:0] m_do;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (n=%0d)", nm, act, exp, n);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a[3:2])
      2'd0: return m_data;
      2'd1: return {24'b0, m_dp};
      2'd2: return {24'b0, m_en};
`ifdef SEG7_BLINK_EN
      2'd3: return {24'b0, m_bl};
`endif
      default: return 32'h0;
    endcase
  endfunction

  // Model: output at the n-th edge after reset release comes from
  // slot (n-1)/SD, using register contents from before that edge.
  initial begin
    int slot, di, frame, ph;
    logic lit;
    logic [7:0] ea, es;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        n = 0;
        m_data = '0; m_dp = '0; m_en = 8'hFF; m_bl = '0; m_do = '0;
        check("rst_an", {24'b0, an_n}, 32'hFF);
        check("rst_seg", {24'b0, seg_n}, 32'hFF);
        check("rst_do", data_o, 32'h0);
      end else begin
        n++;
        slot = (n - 1) / SD;
        di = slot % 8;
        frame = slot / 8;
`ifdef SEG7_BLINK_EN
        ph = (frame / BF) % 2;
`else
        ph = 0;
`endif
        lit = m_en[di] && !(ph == 1 && m_bl[di]);
        ea = lit ? ~(8'(1) << di) : 8'hFF;
        es = lit ? {~m_dp[di], hexc[(m_data >> (4 * di)) & 32'hF]} : 8'hFF;
        check("an", {24'b0, an_n}, {24'b0, ea});
        check("seg", {24'b0, seg_n}, {24'b0, es});
        if (ce && !we) m_do = m_read(addr);
        check("do", data_o, m_do);
        if (ce && we) begin
          case (addr[3:2])
            2'd0: for (int i = 0; i < 4; i++)
                    if (sel[i]) m_data[8*i +: 8] = data_i[8*i +: 8];
            2'd1: if (sel[0]) m_dp = data_i[7:0];
            2'd2: if (sel[0]) m_en = data_i[7:0];
`ifdef SEG7_BLINK_EN
            2'd3: if (sel[0]) m_bl = data_i[7:0];
`endif
            default: ;
          endcase
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic goto(input int t);
    int b = 0;
    while (n < t && b < 1000) begin
      step();
      b++;
    end
    check("goto", n, t);
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] s,
                    input logic [31:0] d);
    ce = 1'b1; we = 1'b1; addr = a; sel = s; data_i = d;
    step();
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    ce = 1'b1; we = 1'b0; addr = a;
    step();
    ce = 1'b0;
  endtask

  task automatic lit_out(input string nm, input logic [7:0] a,
                         input logic [7:0] s);
    check({nm, "_an"}, {24'b0, an_n}, {24'b0, a});
    check({nm, "_seg"}, {24'b0, seg_n}, {24'b0, s});
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) step();
    lit_out("hold_rst", 8'hFF, 8'hFF);
    check("hold_rst_do", data_o, 32'h0);
    rst = 1'b0;
    step();
    lit_out("first", 8'hFE, 8'hC0);
    wr(4'h0, 4'hF, 32'h1234ABCD);
    step();
    lit_out("d0_d", 8'hFE, 8'hA1);
    goto(5);
    lit_out("d1_C", 8'hFD, 8'hC6);
    goto(29);
    lit_out("d7_1", 8'h7F, 8'hF9);
    goto(33);
    lit_out("frame", 8'hFE, 8'hA1);
    wr(4'h0, 4'b0001, 32'hFFFFFFFF);
    rd(4'h0);
    check("rd_data", data_o, 32'h1234ABFF);
    wr(4'h4, 4'hF, 32'hABCDEF02);
    wr(4'h8, 4'hF, 32'h000000FE);
    lit_out("dp1", 8'hFD, 8'h0E);
    rd(4'h4);
    check("rd_dp", data_o, 32'h00000002);
    rd(4'h8);
    check("rd_en", data_o, 32'h000000FE);
    goto(65);
    for (int k = 0; k < SD; k++) begin
      lit_out("off0", 8'hFF, 8'hFF);
      if (k < SD - 1) step();
    end
    goto(69);
    lit_out("d1_on", 8'hFD, 8'h0E);
    wr(4'hC, 4'hF, 32'h00000001);
    rd(4'hC);
`ifdef SEG7_BLINK_EN
    check("rd_blink", data_o, 32'h00000001);
`else
    check("rd_blink", data_o, 32'h00000000);
`endif
    goto(86);
    rst = 1'b1;
    #1;
    lit_out("async_rst", 8'hFF, 8'hFF);
    check("async_rst_do", data_o, 32'h0);
    step();
    step();
    rst = 1'b0;
    step();
    lit_out("restart", 8'hFE, 8'hC0);
    wr(4'hC, 4'hF, 32'h00000001);
    goto(33);
    lit_out("blk_f1", 8'hFE, 8'hC0);
    goto(65);
`ifdef SEG7_BLINK_EN
    lit_out("blk_f2", 8'hFF, 8'hFF);
`else
    lit_out("blk_f2", 8'hFE, 8'hC0);
`endif
    goto(97);
`ifdef SEG7_BLINK_EN
    lit_out("blk_f3", 8'hFF, 8'hFF);
`else
    lit_out("blk_f3", 8'hFE, 8'hC0);
`endif
    goto(129);
    lit_out("blk_f4", 8'hFE, 8'hC0);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
